// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
//
// Produces a registered square wave clk_out with period cur_div clk cycles
// (high for ceil(N/2), low for floor(N/2)) and a one-cycle tick on the first
// cycle of each period. Divisor updates are staged in a pending register and
// only take effect at a period boundary, so clk_out never produces runt pulses.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous active-high reset
//   en       - run enable; low holds the divider idle with outputs low
//   div_val  - requested divisor N (0 and 1 are clamped to 2)
//   div_load - one-cycle strobe capturing div_val into the pending divisor
//   clk_out  - divided clock, registered
//   tick     - one-cycle pulse on the first cycle of each clk_out period
//   cur_div  - divisor governing the current period
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MinDiv = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] load_val;
  logic             period_start;
  logic [WIDTH:0]   half;

  always_comb begin
    load_val     = (div_val < MinDiv) ? MinDiv : div_val;
    // cur_div_q >= 2 always, so the subtraction cannot underflow.
    period_start = en && (!active_q || (cnt_q == (cur_div_q - WIDTH'(1))));

    pend_div_d = div_load ? load_val : pend_div_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    cur_div_d  = cur_div_q;

    if (!en) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (period_start) begin
      cnt_d     = '0;
      active_d  = 1'b1;
      // A load on the boundary edge applies to the period starting now.
      cur_div_d = pend_div_d;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    // High-phase length ceil(N/2) from the divisor that will govern cnt_d.
    half      = ({1'b0, cur_div_d} + (WIDTH+1)'(1)) >> 1;
    clk_out_d = en && ({1'b0, cnt_d} < half);
    tick_d    = period_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      active_q   <= 1'b0;
      pend_div_q <= DefDiv;
      cur_div_q  <= DefDiv;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pend_div_q <= pend_div_d;
      cur_div_q  <= cur_div_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: table of per-cycle vectors with hand-computed
// expected outputs, plus a hand-written long-period (N=255) sequence.
module tb_clk_div_prog;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] cur_div;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_prog #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .clk_out (clk_out),
    .tick    (tick),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] val;
    logic       exp_clk;
    logic       exp_tick;
    logic [7:0] exp_cur;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic l, input logic [7:0] v,
                     input logic c, input logic t, input logic [7:0] d);
    vec_t x;
    x.rst = r; x.en = e; x.load = l; x.val = v;
    x.exp_clk = c; x.exp_tick = t; x.exp_cur = d;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Apply inputs just after an edge, clock once, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic l, input logic [7:0] v);
    rst = r; en = e; div_load = l; div_val = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int highs;
    // Reset, then N=4 free-running: 1,1,0,0.
    add(1, 0, 0, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 4);
    add(0, 1, 0, 0, 1, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 4);
    add(0, 1, 0, 0, 1, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    // Load 5 mid-period: the N=4 period completes, then 1,1,1,0,0.
    add(0, 1, 0, 0, 1, 1, 4);
    add(0, 1, 1, 5, 1, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 5);
    add(0, 1, 0, 0, 1, 0, 5);
    add(0, 1, 0, 0, 1, 0, 5);
    add(0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 0, 0, 5);
    // Load 0 then 1: both clamp to 2.
    add(0, 1, 0, 0, 1, 1, 5);
    add(0, 1, 1, 0, 1, 0, 5);
    add(0, 1, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 1, 1, 2);
    add(0, 1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 1, 1, 2);
    add(0, 1, 0, 0, 0, 0, 2);
    // Load 6 on the same edge as a wrap: applies to the new period at once.
    add(0, 1, 1, 6, 1, 1, 6);
    add(0, 1, 0, 0, 1, 0, 6);
    add(0, 1, 0, 0, 1, 0, 6);
    add(0, 1, 0, 0, 0, 0, 6);
    // en low for 3 cycles mid-period, then a fresh full period.
    add(0, 0, 0, 0, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 1, 1, 6);
    add(0, 1, 0, 0, 1, 0, 6);
    add(0, 1, 0, 0, 1, 0, 6);
    add(0, 1, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 1, 1, 6);
    // N=7, then reset mid-period restores the default divisor.
    add(0, 1, 1, 7, 1, 0, 6);
    add(0, 1, 0, 0, 1, 0, 6);
    add(0, 1, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 0, 0, 6);
    add(0, 1, 0, 0, 1, 1, 7);
    add(0, 1, 0, 0, 1, 0, 7);
    add(0, 1, 0, 0, 1, 0, 7);
    add(1, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 4);
    add(0, 1, 0, 0, 1, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 4);
    // Two loads in one period: the last one (3) wins.
    add(0, 1, 1, 9, 1, 0, 4);
    add(0, 1, 1, 3, 0, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 3);
    add(0, 1, 0, 0, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 1, 1, 3);
    // Queue N=255 for the long-period sequence below.
    add(0, 1, 1, 255, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 1, 1, 255);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].val);
      check("clk_out", i, 32'(clk_out), 32'(vecs[i].exp_clk));
      check("tick", i, 32'(tick), 32'(vecs[i].exp_tick));
      check("cur_div", i, 32'(cur_div), 32'(vecs[i].exp_cur));
    end

    // N=255: the first cycle of the period was just sampled above (high).
    highs = 1;
    for (int k = 1; k < 255; k++) begin
      step(0, 1, 0, 0);
      check("n255_clk_out", k, 32'(clk_out), (k < 128) ? 32'd1 : 32'd0);
      check("n255_tick", k, 32'(tick), 32'd0);
      if (clk_out) highs++;
    end
    check("n255_high_count", 255, 32'(highs), 32'd128);
    // Wrap after exactly 255 cycles, no extra cycle.
    step(0, 1, 0, 0);
    check("n255_wrap_tick", 256, 32'(tick), 32'd1);
    check("n255_wrap_clk_out", 256, 32'(clk_out), 32'd1);
    check("n255_wrap_cur_div", 256, 32'(cur_div), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
